// File: rtl/trace_if.sv
// TPIU trace port receiver: captures 1/2/4-lane DDR trace data, hunts for the
// FF FF FF 7F frame sync and assembles 16-byte frames into Packet.
module trace_if (
  input  logic         traceClkin,
  input  logic         rst,
  input  logic [3:0]   traceDina,
  input  logic [3:0]   traceDinb,
  input  logic [1:0]   width,
  output logic         PkAvail,
  output logic [127:0] Packet
);

  typedef enum logic {UNSYNCED, SYNCED} state_e;

  state_e         state_q, state_d;
  logic [31:0]    win_q, win_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [127:0]   frame_q, frame_d;
  logic [127:0]   packet_q, packet_d;
  logic           pk_avail_q, pk_avail_d;

  logic [7:0]     edge_bits;
  int unsigned    nbits;
  logic           sync_hit;
  logic [6:0]     ptr;
  logic [7:0]     ptr_sum;

  // Stream order per edge: traceDina lanes first, then traceDinb lanes.
  always_comb begin
    edge_bits = '0;
    nbits     = 2;
    unique case (width)
      2'd3: begin
        edge_bits = {traceDinb, traceDina};
        nbits     = 8;
      end
      2'd2: begin
        edge_bits = {4'b0000, traceDinb[1:0], traceDina[1:0]};
        nbits     = 4;
      end
      default: begin
        edge_bits = {6'b000000, traceDinb[0], traceDina[0]};
        nbits     = 2;
      end
    endcase
    win_d = win_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) win_d = {edge_bits[3'(i)], win_d[31:1]};
    end
  end

  assign sync_hit = (win_d == 32'h7FFF_FFFF);

  always_ff @(posedge traceClkin) begin
    if (rst) state_q <= UNSYNCED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sync_hit) state_d = SYNCED;
  end

  // Bit pointer into the frame is {byte_cnt, bit_cnt}; nbits always divides 8,
  // so an edge never straddles the end of the frame.
  always_comb begin
    ptr        = {byte_cnt_q, bit_cnt_q};
    ptr_sum    = {1'b0, ptr} + 8'(nbits);
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    packet_d   = packet_q;
    pk_avail_d = 1'b0;
    if (sync_hit) begin
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      frame_d    = '0;
    end else if (state_q == SYNCED) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i < nbits) frame_d[7'(32'(ptr) + i)] = edge_bits[3'(i)];
      end
      {byte_cnt_d, bit_cnt_d} = ptr_sum[6:0];
      if (ptr_sum[7]) begin
        packet_d   = frame_d;
        pk_avail_d = 1'b1;
        frame_d    = '0;
      end
    end
  end

  always_ff @(posedge traceClkin) begin
    if (rst) begin
      win_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      frame_q    <= '0;
      packet_q   <= '0;
      pk_avail_q <= 1'b0;
    end else begin
      win_q      <= win_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      frame_q    <= frame_d;
      packet_q   <= packet_d;
      pk_avail_q <= pk_avail_d;
    end
  end

  assign PkAvail = pk_avail_q;
  assign Packet  = packet_q;

endmodule

// File: tb/tb_trace_if.sv
// Directed bench for trace_if: drives byte streams at each port width and
// checks frame contents and PkAvail pulse counts against hand-computed values.
module tb_trace_if;

  logic         clk;
  logic         rst;
  logic [3:0]   dina;
  logic [3:0]   dinb;
  logic [1:0]   width;
  logic         pk;
  logic [127:0] packet;

  int unsigned  vec_cnt;
  int unsigned  err_cnt;
  int unsigned  pulses;
  logic         pk_last;

  localparam logic [127:0] FRAME_A = 128'h0F0E0D0C0B0A09080706050403023412;
  localparam logic [127:0] FRAME_B = 128'h0F0E0D0C0B0A09080706050403020100;

  trace_if dut (
    .traceClkin (clk),
    .rst        (rst),
    .traceDina  (dina),
    .traceDinb  (dinb),
    .width      (width),
    .PkAvail    (pk),
    .Packet     (packet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] w);
    @(negedge clk);
    rst   = 1'b1;
    width = w;
    dina  = '0;
    dinb  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One byte, LSB first, split into per-edge chunks for the current width.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    int unsigned chunk;
    n     = (width == 2'd3) ? 8 : (width == 2'd2) ? 4 : 2;
    chunk = n / 2;
    for (int unsigned e = 0; e < 8 / n; e++) begin
      @(negedge clk);
      dina = '0;
      dinb = '0;
      for (int unsigned j = 0; j < chunk; j++) begin
        dina[2'(j)] = b[3'(e * n + j)];
        dinb[2'(j)] = b[3'(e * n + chunk + j)];
      end
      @(posedge clk);
      #1;
      pk_last = pk;
      if (pk) pulses++;
    end
  endtask

  task automatic send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h7F);
  endtask

  task automatic send_frame_a();
    send_byte(8'h12);
    send_byte(8'h34);
    for (int unsigned k = 2; k < 16; k++) send_byte(8'(k));
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    pulses  = 0;
    pk_last = 1'b0;
    rst     = 1'b1;
    width   = 2'd3;
    dina    = '0;
    dinb    = '0;

    do_reset(2'd3);
    @(posedge clk); #1;
    check("reset_pk", 128'(pk), 128'd0);
    check("reset_packet", packet, '0);

    // No sync: data ignored
    pulses = 0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h99); send_byte(8'h88);
    check("nosync_pulses", 128'(pulses), 128'd0);
    check("nosync_packet", packet, '0);

    // Sync then one frame at width=3
    pulses = 0;
    send_byte(8'h55); send_byte(8'hA3);
    send_sync();
    send_frame_a();
    check("w3_pk_on_last", 128'(pk_last), 128'd1);
    check("w3_pulses", 128'(pulses), 128'd1);
    check("w3_packet", packet, FRAME_A);
    send_byte(8'h0E);
    check("w3_pk_drop", 128'(pk_last), 128'd0);

    // Half a frame more: no pulse, packet holds
    pulses = 0;
    for (int unsigned r = 0; r < 4; r++) begin
      send_byte(8'h0E);
      send_byte(8'h0F);
    end
    check("partial_pulses", 128'(pulses), 128'd0);
    check("partial_packet", packet, FRAME_A);

    // Same frame at narrower widths
    for (int unsigned wi = 0; wi < 3; wi++) begin
      do_reset(2'(2 - wi));
      check("wn_reset_packet", packet, '0);
      pulses = 0;
      send_byte(8'h3C);
      send_sync();
      send_frame_a();
      check("wn_pulses", 128'(pulses), 128'd1);
      check("wn_packet", packet, FRAME_A);
    end

    // Re-sync inside a frame discards the partial frame
    for (int unsigned vi = 0; vi < 2; vi++) begin
      do_reset(2'd3);
      pulses = 0;
      send_sync();
      for (int unsigned k = 0; k < ((vi == 0) ? 8 : 12); k++) send_byte(8'(8'hA0 + k));
      send_sync();
      check("resync_no_pulse", 128'(pulses), 128'd0);
      for (int unsigned k = 0; k < 16; k++) send_byte(8'(k));
      check("resync_pulses", 128'(pulses), 128'd1);
      check("resync_packet", packet, FRAME_B);
    end

    // Reset mid-frame: back to unsynced, packet cleared
    pulses = 0;
    for (int unsigned k = 0; k < 6; k++) send_byte(8'(8'h40 + k));
    do_reset(2'd3);
    check("midrst_packet", packet, '0);
    for (int unsigned k = 0; k < 16; k++) send_byte(8'(k));
    check("midrst_pulses", 128'(pulses), 128'd0);
    check("midrst_packet_after", packet, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/trace_if.md
TRACE_IF -- requirements
Module: trace_if

Interface
REQ-001 The block SHALL have one clock, traceClkin; reset is synchronous and active-high.
REQ-002 traceClkin  input  1  trace port clock, sole clock of the block; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on traceClkin rising edge.
REQ-004 traceDina  input  4  trace data for the first half-cycle (earlier bits); only lanes [chunk-1:0] are used.
REQ-005 traceDinb  input  4  trace data for the second half-cycle (later bits); only lanes [chunk-1:0] are used.
REQ-006 width  input  2  port width: 3 = 4 lanes, 2 = 2 lanes, 1 or 0 = 1 lane; static between resets.
REQ-007 PkAvail  output  1  packet-available strobe, registered.
REQ-008 Packet  output  128  last complete 16-byte TPIU frame, registered.

Function
REQ-009 Chunk width SHALL be 4 bits when width=3, 2 bits when width=2, and 1 bit when width=0 or 1; unused lanes are ignored.
REQ-010 Each traceClkin rising edge SHALL capture 2×chunk bits in stream order: traceDina[chunk-1:0] first, then traceDinb[chunk-1:0], each LSB first.
REQ-011 Bits per edge SHALL be 8 for width=3, 4 for width=2, and 2 for width=0/1, so one byte takes 1, 2 or 4 edges.
REQ-012 Stream bits SHALL form bytes LSB first: the first bit received is byte bit 0.
REQ-013 A 32-bit sync window SHALL shift right with each new bit entering at bit 31, updated every edge with all captured bits, in or out of sync.
REQ-014 Sync SHALL be detected when the window equals 0x7FFFFFFF after an edge, i.e. bytes FF FF FF 7F received in that order.
REQ-015 States: UNSYNCED (after reset) and SYNCED; sync detection in either state enters SYNCED, clears the bit/byte counters, and discards any partial frame.
REQ-016 In UNSYNCED, data SHALL be ignored except for sync detection; no packet is produced.
REQ-017 In SYNCED, bits following the sync edge SHALL be assembled into bytes; byte k (k=0..15) of a frame goes to Packet[8k+7:8k].
REQ-018 On the edge that captures the last bit of byte 15, the 128-bit frame SHALL be loaded into Packet and PkAvail set to 1; the byte counter wraps to 0.
REQ-019 PkAvail SHALL be 1 for exactly one traceClkin cycle per frame and 0 otherwise.
REQ-020 Packet SHALL hold its value until the next frame completes.
REQ-021 Only sync detection SHALL leave the SYNCED state, apart from rst.
REQ-022 A sync pattern occurring inside frame data SHALL re-align the frame, with the partial frame discarded and no PkAvail.
REQ-023 If traceClkin stops, outputs SHALL hold their last values (no activity without a clock edge).
REQ-024 Changing width without rst SHALL be undefined; the bench applies rst around width changes.

Reset
REQ-025 While rst=1 at a rising edge: PkAvail=0, Packet=0, state UNSYNCED, sync window=0, bit/byte counters=0.
REQ-026 rst SHALL take priority over all data capture on the same edge.

Verification
REQ-027 width=3, bytes 00 00 00 99 88 with no sync -> PkAvail stays 0, Packet=0.
REQ-028 width=3, junk then FF FF FF 7F, then 12 34 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F -> single one-cycle PkAvail pulse, Packet=0x0F0E0D0C0B0A09080706050403023412.
REQ-029 After REQ-028, send 0E 0F ×4 (8 bytes) -> no further PkAvail, Packet unchanged.
REQ-030 Repeat REQ-028 with width=2 and width=1 (2 and 4 edges per byte) -> identical Packet value and one pulse each.
REQ-031 Sync, 8 data bytes, sync again, 16 bytes 00..0F -> one pulse, Packet=0x0F0E0D0C0B0A09080706050403020100.
REQ-032 Assert rst mid-frame, then send 16 bytes without sync -> no PkAvail, Packet=0.
